// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : wisc_pkg
//  Purpose : Shared encodings for the WISC core control path: opcodes,
//            branch condition codes, flag bit positions and the PC-stage
//            RUN/HALT state type.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package wisc_pkg;

  // Opcodes, instr[15:12]
  localparam logic [3:0] ADD    = 4'h0;
  localparam logic [3:0] SUB    = 4'h1;
  localparam logic [3:0] RED    = 4'h2;
  localparam logic [3:0] XOR    = 4'h3;
  localparam logic [3:0] SLL    = 4'h4;
  localparam logic [3:0] SRA    = 4'h5;
  localparam logic [3:0] ROR    = 4'h6;
  localparam logic [3:0] PADDSB = 4'h7;
  localparam logic [3:0] LW     = 4'h8;
  localparam logic [3:0] SW     = 4'h9;
  localparam logic [3:0] LHB    = 4'hA;
  localparam logic [3:0] LLB    = 4'hB;
  localparam logic [3:0] B      = 4'hC;
  localparam logic [3:0] BR     = 4'hD;
  localparam logic [3:0] PCS    = 4'hE;
  localparam logic [3:0] HLT    = 4'hF;

  // Branch condition codes, instr[11:9]
  localparam logic [2:0] NE     = 3'b000;
  localparam logic [2:0] EQ     = 3'b001;
  localparam logic [2:0] GT     = 3'b010;
  localparam logic [2:0] LT     = 3'b011;
  localparam logic [2:0] GE     = 3'b100;
  localparam logic [2:0] LE     = 3'b101;
  localparam logic [2:0] OV     = 3'b110;
  localparam logic [2:0] UNCOND = 3'b111;

  // Flag register bit positions, flags = {Z,V,N}
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage : wisc_pkg
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module  : branch_cond_eval
//  Purpose : Combinational branch condition evaluation against the flag
//            register contents.
//  Ports   : i_cond      [2:0]  condition code
//            i_flags     [2:0]  {Z,V,N}
//            o_cond_true        condition satisfied
//  Rev     : 1.0  initial release
// ============================================================================
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic [2:0] i_flags,
  output logic       o_cond_true
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = i_flags[FLAG_Z];
  assign w_v = i_flags[FLAG_V];
  assign w_n = i_flags[FLAG_N];

  always_comb begin
    o_cond_true = 1'b0;
    case (i_cond)
      NE:      o_cond_true = !w_z;
      EQ:      o_cond_true = w_z;
      GT:      o_cond_true = !w_z && !w_n;
      LT:      o_cond_true = w_n;
      GE:      o_cond_true = w_z || (!w_z && !w_n);
      LE:      o_cond_true = w_n || w_z;
      OV:      o_cond_true = w_v;
      UNCOND:  o_cond_true = 1'b1;
      default: o_cond_true = 1'b0;
    endcase
  end

endmodule : branch_cond_eval
`default_nettype wire

// File: rtl/pc_control.sv
`default_nettype none
// ============================================================================
//  Module  : pc_control
//  Purpose : Program counter, Z/V/N flag register, branch resolution and
//            RUN/HALT control for the single-cycle WISC core.
//  Ports   : clk, rst_n            clock, async active-low reset
//            opcode/cond/imm9      instruction fields
//            reg_rs     [PC_W]     BR target from register file
//            branch                decoded branch instruction
//            alu_z/v/n             ALU flags of current instruction
//            stall                 hold all state this cycle
//            pc         [PC_W]     current PC (registered)
//            pc_plus2   [PC_W]     pc+2 (combinational)
//            taken                 branch taken this cycle (combinational)
//            flags      [2:0]      {Z,V,N} (registered)
//            halt                  core halted (registered)
//  Rev     : 1.0  initial release
// ============================================================================
module pc_control
  import wisc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      opcode,
  input  logic [2:0]      cond,
  input  logic [8:0]      imm9,
  input  logic [PC_W-1:0] reg_rs,
  input  logic            branch,
  input  logic            alu_z,
  input  logic            alu_v,
  input  logic            alu_n,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic            taken,
  output logic [2:0]      flags,
  output logic            halt
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [2:0]      r_flags;
  logic [2:0]      w_flags_nxt;
  logic            w_cond_true;
  logic [PC_W-1:0] w_pc_plus2;
  logic [PC_W-1:0] w_imm_sext;
  logic [PC_W-1:0] w_b_target;

  // Condition is evaluated on the registered flags, so a flag-setting
  // instruction in the same cycle cannot influence its own branch.
  branch_cond_eval u_cond (
    .i_cond      (cond),
    .i_flags     (r_flags),
    .o_cond_true (w_cond_true)
  );

  assign w_pc_plus2 = r_pc + PC_W'(2);
  assign w_imm_sext = {{(PC_W-9){imm9[8]}}, imm9};
  // Word offset: shift left by one; sum wraps modulo 2^PC_W.
  assign w_b_target = w_pc_plus2 + {w_imm_sext[PC_W-2:0], 1'b0};

  assign taken    = branch && w_cond_true && (r_state == RUN);
  assign pc       = r_pc;
  assign pc_plus2 = w_pc_plus2;
  assign flags    = r_flags;
  assign halt     = (r_state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_flags <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flags_nxt = r_flags;
    // Stall and HALT both freeze every piece of state.
    if (r_state == RUN && !stall) begin
      if (opcode == HLT) begin
        w_state_nxt = HALT;
      end else if (taken) begin
        // opcode[0] distinguishes BR (register target) from B (relative).
        w_pc_nxt = opcode[0] ? reg_rs : w_b_target;
      end else begin
        w_pc_nxt = w_pc_plus2;
      end

      case (opcode)
        ADD, SUB: begin
          w_flags_nxt[FLAG_Z] = alu_z;
          w_flags_nxt[FLAG_V] = alu_v;
          w_flags_nxt[FLAG_N] = alu_n;
        end
        XOR, SLL, SRA, ROR: w_flags_nxt[FLAG_Z] = alu_z;
        default: ;
      endcase
    end
  end

endmodule : pc_control
`default_nettype wire

// File: tb/tb_pc_control.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pc_control
//  Purpose : Directed self-checking bench for pc_control.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pc_control;

  logic        clk;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] reg_rs;
  logic        branch;
  logic        alu_z;
  logic        alu_v;
  logic        alu_n;
  logic        stall;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        taken;
  logic [2:0]  flags;
  logic        halt;

  int n_pass;
  int n_total;

  pc_control #(
    .PC_W     (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .cond     (cond),
    .imm9     (imm9),
    .reg_rs   (reg_rs),
    .branch   (branch),
    .alu_z    (alu_z),
    .alu_v    (alu_v),
    .alu_n    (alu_n),
    .stall    (stall),
    .pc       (pc),
    .pc_plus2 (pc_plus2),
    .taken    (taken),
    .flags    (flags),
    .halt     (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One instruction: drive, check taken before the edge, check state after.
  task automatic cyc(input string tag,
                     input logic [3:0] op, input logic [2:0] cd, input logic [8:0] im,
                     input logic [15:0] rs, input logic br, input logic [2:0] zvn,
                     input logic st, input logic exp_taken, input logic [15:0] exp_pc,
                     input logic [2:0] exp_flags, input logic exp_halt);
    opcode = op; cond = cd; imm9 = im; reg_rs = rs; branch = br;
    alu_z = zvn[2]; alu_v = zvn[1]; alu_n = zvn[0]; stall = st;
    #1;
    check({tag, ".taken"}, {15'd0, taken}, {15'd0, exp_taken});
    @(posedge clk);
    #1;
    check({tag, ".pc"}, pc, exp_pc);
    check({tag, ".flags"}, {13'd0, flags}, {13'd0, exp_flags});
    check({tag, ".halt"}, {15'd0, halt}, {15'd0, exp_halt});
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; opcode = 4'h8; cond = 3'b000; imm9 = 9'h000; reg_rs = 16'h0000;
    branch = 1'b0; alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc", pc, 16'h0000);
    check("rst.flags", {13'd0, flags}, 16'h0000);
    check("rst.halt", {15'd0, halt}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: sequential fetch
    cyc("seq0", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0002, 3'b000, 1'b0);
    cyc("seq1", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0004, 3'b000, 1'b0);
    cyc("seq2", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0006, 3'b000, 1'b0);
    cyc("seq3", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0008, 3'b000, 1'b0);
    cyc("seq4", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h000A, 3'b000, 1'b0);
    cyc("seq5", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h000C, 3'b000, 1'b0);
    cyc("seq6", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h000E, 3'b000, 1'b0);

    // 2: ADD sets Z, then B EQ backward by -2 words from pc 0010
    cyc("add_z", 4'h0, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b100, 1'b0, 1'b0, 16'h0010, 3'b100, 1'b0);
    opcode = 4'hC; #1;
    check("b_eq.pc_plus2", pc_plus2, 16'h0012);
    cyc("b_eq", 4'hC, 3'b001, 9'h1FE, 16'h0000, 1'b1, 3'b000, 1'b0, 1'b1, 16'h000E, 3'b100, 1'b0);

    // 3: SUB sets N, BR GT not taken, BR LT taken
    cyc("sub_n", 4'h1, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b001, 1'b0, 1'b0, 16'h0010, 3'b001, 1'b0);
    cyc("br_gt", 4'hD, 3'b010, 9'h000, 16'h1234, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0012, 3'b001, 1'b0);
    cyc("br_lt", 4'hD, 3'b011, 9'h000, 16'h1234, 1'b1, 3'b000, 1'b0, 1'b1, 16'h1234, 3'b001, 1'b0);

    // 4: wrap-around
    cyc("br_fffe", 4'hD, 3'b111, 9'h000, 16'hFFFE, 1'b1, 3'b000, 1'b0, 1'b1, 16'hFFFE, 3'b001, 1'b0);
    opcode = 4'h8; branch = 1'b0; #1;
    check("wrap.pc_plus2", pc_plus2, 16'h0000);
    cyc("wrap", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b001, 1'b0);
    cyc("br_ff00", 4'hD, 3'b111, 9'h000, 16'hFF00, 1'b1, 3'b000, 1'b0, 1'b1, 16'hFF00, 3'b001, 1'b0);
    cyc("b_wrap", 4'hC, 3'b111, 9'h0FF, 16'h0000, 1'b1, 3'b000, 1'b0, 1'b1, 16'h0100, 3'b001, 1'b0);

    // 5: partial flag update and flag hold
    cyc("add_v", 4'h0, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b010, 1'b0, 1'b0, 16'h0102, 3'b010, 1'b0);
    cyc("xor_z", 4'h3, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b111, 1'b0, 1'b0, 16'h0104, 3'b110, 1'b0);
    cyc("lw_hold", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b111, 1'b0, 1'b0, 16'h0106, 3'b110, 1'b0);
    cyc("sub_stall", 4'h1, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 16'h0106, 3'b110, 1'b0);
    cyc("b_stall", 4'hC, 3'b111, 9'h010, 16'h0000, 1'b1, 3'b000, 1'b1, 1'b1, 16'h0106, 3'b110, 1'b0);

    // 6: HLT under stall, HLT, frozen HALT state, reset out of HALT
    cyc("hlt_stall", 4'hF, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 16'h0106, 3'b110, 1'b0);
    cyc("hlt", 4'hF, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0106, 3'b110, 1'b1);
    cyc("halt_b", 4'hC, 3'b111, 9'h010, 16'h0000, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0106, 3'b110, 1'b1);
    cyc("halt_add", 4'h0, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0106, 3'b110, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst.pc", pc, 16'h0000);
    check("arst.flags", {13'd0, flags}, 16'h0000);
    check("arst.halt", {15'd0, halt}, 16'h0000);
    #2;
    rst_n = 1'b1;
    cyc("post_rst", 4'h8, 3'b000, 9'h000, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0002, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pc_control
`default_nettype wire
